// File: rtl/matrix_pixel_streamer_pkg.sv
// Shared types and constants for the occupancy-matrix to LED-chain streamer.
package matrix_pixel_streamer_pkg;

    localparam int PANEL_DIM   = 16;
    localparam int PIXEL_COUNT = PANEL_DIM * PANEL_DIM;

    // One LED word in WS2812 wire order: green, red, blue.
    typedef logic [23:0] grb_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_LATCH
    } streamer_state_t;

endpackage

// File: rtl/matrix_pixel_streamer_pixel_index_map.sv
// Maps a linear chain position onto the panel's row/column, honouring
// serpentine wiring where odd rows are laid right-to-left.
module matrix_pixel_streamer_pixel_index_map
    import matrix_pixel_streamer_pkg::*;
#(
    parameter bit SERPENTINE = 1'b1
) (
    input  logic [7:0] idx,
    output logic [3:0] row,
    output logic [3:0] col
);

    // Upper nibble selects the row, lower nibble the position along it.
    always_comb begin
        row = idx[7:4];
        col = (SERPENTINE && idx[4]) ? (4'd15 - idx[3:0]) : idx[3:0];
    end

endmodule

// File: rtl/matrix_pixel_streamer.sv
// Snapshots the 16x16 occupancy matrix on request and streams 256 GRB words
// in panel wiring order over valid/ready, then holds a latch gap so the LED
// chain commits the frame before signalling frame_done.
module matrix_pixel_streamer
    import matrix_pixel_streamer_pkg::*;
#(
    parameter grb_t ON_COLOR     = 24'h10_10_10,
    parameter grb_t OFF_COLOR    = 24'h00_00_00,
    parameter bit   SERPENTINE   = 1'b1,
    parameter int   LATCH_CYCLES = 3000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic matrix [PANEL_DIM-1:0][PANEL_DIM-1:0],
    input  logic frame_req,
    output logic pixel_valid,
    input  logic pixel_ready,
    output grb_t pixel_data,
    output logic pixel_last,
    output logic busy,
    output logic frame_done
);

    localparam int         CW       = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [7:0] LAST_IDX = 8'(PIXEL_COUNT - 1);

    streamer_state_t          state;
    logic [7:0]               idx;
    logic [CW-1:0]            latch_cnt;
    logic                     pending;
    logic [PIXEL_COUNT-1:0]   snap;
    logic [PIXEL_COUNT-1:0]   matrix_flat;
    logic [7:0]               next_idx;
    logic [3:0]               map_row;
    logic [3:0]               map_col;
    logic                     next_bit;

    function automatic grb_t pick(input logic occupied);
        return occupied ? ON_COLOR : OFF_COLOR;
    endfunction

    // Flatten the live matrix so a snapshot is a single register load.
    always_comb begin
        matrix_flat = '0;
        for (int r = 0; r < PANEL_DIM; r++) begin
            for (int c = 0; c < PANEL_DIM; c++) begin
                matrix_flat[{4'(r), 4'(c)}] = matrix[r][c];
            end
        end
    end

    // The word after the current one is prepared ahead so that a transfer
    // can be followed by the next pixel without a bubble.
    always_comb begin
        next_idx = idx + 8'd1;
        next_bit = snap[{map_row, map_col}];
    end

    matrix_pixel_streamer_pixel_index_map #(
        .SERPENTINE(SERPENTINE)
    ) u_index_map (
        .idx(next_idx),
        .row(map_row),
        .col(map_col)
    );

    // Frame sequencer with registered handshake and status outputs. Pixel 0
    // is always row 0 column 0 (row 0 is never reversed), so it is taken
    // straight from the live matrix on the snapshot edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            latch_cnt   <= '0;
            pending     <= 1'b0;
            snap        <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_last  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_req) begin
                        snap        <= matrix_flat;
                        idx         <= '0;
                        pixel_valid <= 1'b1;
                        pixel_data  <= pick(matrix_flat[0]);
                        pixel_last  <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (frame_req) begin
                        pending <= 1'b1;
                    end
                    if (pixel_valid && pixel_ready) begin
                        if (idx == LAST_IDX) begin
                            pixel_valid <= 1'b0;
                            pixel_last  <= 1'b0;
                            latch_cnt   <= CW'(LATCH_CYCLES - 1);
                            frame_done  <= (LATCH_CYCLES == 1);
                            state       <= ST_LATCH;
                        end else begin
                            idx        <= next_idx;
                            pixel_data <= pick(next_bit);
                            pixel_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt == '0) begin
                        if (pending || frame_req) begin
                            pending     <= 1'b0;
                            snap        <= matrix_flat;
                            idx         <= '0;
                            pixel_valid <= 1'b1;
                            pixel_data  <= pick(matrix_flat[0]);
                            pixel_last  <= 1'b0;
                            state       <= ST_STREAM;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (frame_req) begin
                            pending <= 1'b1;
                        end
                        latch_cnt  <= latch_cnt - CW'(1);
                        frame_done <= (latch_cnt == CW'(1));
                    end
                end
                default: begin
                    pixel_valid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_pixel_streamer.sv
// Bench for matrix_pixel_streamer: a serpentine and a straight-wired instance
// share stimulus; expected pixels are queued at request time and popped on
// every accepted transfer.
module tb_matrix_pixel_streamer;

    localparam logic [23:0] ON_C  = 24'h10_10_10;
    localparam logic [23:0] OFF_C = 24'h00_00_00;
    localparam int          L     = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_req;
    logic        pixel_ready;
    logic        matrix [15:0][15:0];
    logic        pixel_valid, pixel_last, busy, frame_done;
    logic [23:0] pixel_data;
    logic        valid0, last0, busy0, done0;
    logic [23:0] data0;

    int          total = 0;
    int          bad   = 0;
    logic [24:0] exp_q[$];
    logic [24:0] exp0_q[$];

    always #5 clk = ~clk;

    matrix_pixel_streamer #(
        .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .SERPENTINE(1'b1), .LATCH_CYCLES(L)
    ) dut (
        .clk(clk), .rst_n(rst_n), .matrix(matrix), .frame_req(frame_req),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .pixel_data(pixel_data), .pixel_last(pixel_last),
        .busy(busy), .frame_done(frame_done)
    );

    matrix_pixel_streamer #(
        .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .SERPENTINE(1'b0), .LATCH_CYCLES(L)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .matrix(matrix), .frame_req(frame_req),
        .pixel_valid(valid0), .pixel_ready(pixel_ready),
        .pixel_data(data0), .pixel_last(last0),
        .busy(busy0), .frame_done(done0)
    );

    task automatic clear_matrix();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                matrix[r][c] = 1'b0;
    endtask

    // Queue the frame both instances must produce from the current matrix.
    task automatic push_frame();
        for (int i = 0; i < 256; i++) begin
            int r, c, cs;
            logic lst;
            r   = i / 16;
            c   = i % 16;
            cs  = (r % 2 == 1) ? 15 - c : c;
            lst = (i == 255) ? 1'b1 : 1'b0;
            exp_q.push_back({matrix[r][cs] ? ON_C : OFF_C, lst});
            exp0_q.push_back({matrix[r][c] ? ON_C : OFF_C, lst});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the sampling edge.
    task automatic request_frame();
        frame_req = 1'b1;
        push_frame();
        @(posedge clk); #1;
        frame_req = 1'b0;
    endtask

    // Accept pixels with the given ready probability until stop_after
    // transfers, checking order, content and stability under stall.
    task automatic drain(input int pct, input int stop_after, output int cycles);
        int          got;
        logic        stalled;
        logic [24:0] held;
        logic [24:0] e;
        got         = 0;
        cycles      = 0;
        stalled     = 1'b0;
        held        = '0;
        pixel_ready = ($urandom_range(99) < pct);
        while (got < stop_after && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            if (stalled && pixel_valid) begin
                total++;
                if ({pixel_data, pixel_last} !== held) begin
                    bad++;
                    $display("FAIL stall_hold pixel %0d: got %h, held %h", got, {pixel_data, pixel_last}, held);
                end
            end
            if (valid0 && pixel_ready) begin
                total++;
                if (exp0_q.size() == 0) begin
                    bad++;
                    $display("FAIL straight_extra_pixel: got %h, expected none", {data0, last0});
                end else begin
                    e = exp0_q.pop_front();
                    if ({data0, last0} !== e) begin
                        bad++;
                        $display("FAIL straight_pixel %0d: got %h, expected %h", got, {data0, last0}, e);
                    end
                end
            end
            if (pixel_valid && pixel_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL serp_extra_pixel: got %h, expected none", {pixel_data, pixel_last});
                end else begin
                    e = exp_q.pop_front();
                    if ({pixel_data, pixel_last} !== e) begin
                        bad++;
                        $display("FAIL serp_pixel %0d: got %h, expected %h", got, {pixel_data, pixel_last}, e);
                    end
                end
                got++;
                stalled = 1'b0;
            end else begin
                stalled = pixel_valid;
                held    = {pixel_data, pixel_last};
            end
            if (got < stop_after) begin
                @(posedge clk); #1;
                pixel_ready = ($urandom_range(99) < pct);
            end
        end
        if (got < stop_after) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d transfers, expected %0d", got, stop_after);
        end
    endtask

    // Count cycles from the last accepted pixel until frame_done; ends at
    // posedge+1 after the edge that closes the frame_done cycle.
    task automatic wait_done(output int k);
        logic seen;
        int   leaks;
        k     = 0;
        seen  = 1'b0;
        leaks = 0;
        while (!seen && k < L + 50) begin
            @(negedge clk);
            k++;
            if (pixel_valid !== 1'b0 || busy !== 1'b1) leaks++;
            if (frame_done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL frame_done_timeout: no pulse in %0d cycles, expected at %0d", k, L);
        end
        total++;
        if (leaks !== 0) begin
            bad++;
            $display("FAIL latch_gap_quiet: %0d cycles with valid/busy wrong, expected 0", leaks);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        frame_req   = 1'b0;
        pixel_ready = 1'b0;
        clear_matrix();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({pixel_valid, pixel_last, busy, frame_done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b, expected 0000", {pixel_valid, pixel_last, busy, frame_done});
        end
        total++;
        if (pixel_data !== 24'h0) begin
            bad++;
            $display("FAIL reset_data: got %h, expected 000000", pixel_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_pixel();
        int cyc, k;
        clear_matrix();
        matrix[0][0] = 1'b1;
        pixel_ready  = 1'b1;
        request_frame();
        total++;
        if (pixel_valid !== 1'b1 || pixel_data !== ON_C) begin
            bad++;
            $display("FAIL first_pixel_latency: valid=%b data=%h, expected valid=1 data=%h", pixel_valid, pixel_data, ON_C);
        end
        drain(100, 256, cyc);
        total++;
        if (cyc !== 256) begin
            bad++;
            $display("FAIL back_to_back: %0d cycles for 256 pixels, expected 256", cyc);
        end
        wait_done(k);
        total++;
        if (k !== L) begin
            bad++;
            $display("FAIL latch_length: frame_done after %0d cycles, expected %0d", k, L);
        end
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || pixel_valid !== 1'b0) begin
            bad++;
            $display("FAIL back_to_idle: done=%b busy=%b valid=%b, expected 0 0 0", frame_done, busy, pixel_valid);
        end
    endtask

    task automatic test_serpentine();
        int cyc, k;
        clear_matrix();
        matrix[1][0] = 1'b1;
        request_frame();
        drain(100, 256, cyc);
        wait_done(k);
    endtask

    task automatic test_backpressure();
        int cyc, k;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                matrix[r][c] = ((r + c) % 2) == 1;
        request_frame();
        drain(50, 256, cyc);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL backpressure_count: %0d pixels missing, expected 0", exp_q.size());
        end
        wait_done(k);
    endtask

    task automatic test_pending();
        int cyc, k, extra;
        clear_matrix();
        matrix[3][7]  = 1'b1;
        matrix[14][2] = 1'b1;
        pixel_ready   = 1'b0;
        request_frame();
        repeat (2) @(posedge clk);
        #1;
        frame_req = 1'b1;
        push_frame();
        @(posedge clk); #1;
        frame_req = 1'b0;
        @(posedge clk); #1;
        frame_req = 1'b1;
        @(posedge clk); #1;
        frame_req = 1'b0;
        drain(100, 256, cyc);
        wait_done(k);
        total++;
        if (pixel_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pending_restart: valid=%b busy=%b, expected 1 1", pixel_valid, busy);
        end
        drain(100, 256, cyc);
        wait_done(k);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (pixel_valid !== 1'b0 || busy !== 1'b0) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL no_third_frame: %0d active cycles, expected 0", extra);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_snapshot();
        int cyc, k;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                matrix[r][c] = ((r * 3 + c) % 5) == 0;
        request_frame();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                matrix[r][c] = ~matrix[r][c];
        drain(100, 256, cyc);
        wait_done(k);
    endtask

    task automatic test_reset_mid();
        int cyc, k, idle_bad;
        clear_matrix();
        for (int r = 0; r < 16; r++) matrix[r][r] = 1'b1;
        request_frame();
        drain(100, 100, cyc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pixel_valid, busy, pixel_last} !== 3'b000) begin
            bad++;
            $display("FAIL async_abort: valid/busy/last=%b, expected 000", {pixel_valid, busy, pixel_last});
        end
        exp_q.delete();
        exp0_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pixel_valid !== 1'b0 || busy !== 1'b0) idle_bad++;
        end
        total++;
        if (idle_bad !== 0) begin
            bad++;
            $display("FAIL post_reset_idle: %0d active cycles, expected 0", idle_bad);
        end
        @(posedge clk); #1;
        request_frame();
        drain(100, 256, cyc);
        wait_done(k);
        total++;
        if (exp_q.size() !== 0 || exp0_q.size() !== 0) begin
            bad++;
            $display("FAIL restart_complete: %0d/%0d pixels left, expected 0/0", exp_q.size(), exp0_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_serpentine();
        test_backpressure();
        test_pending();
        test_snapshot();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
